prio_encoder_rr: RTL and testbench

- Parametrised, registered priority encoder. Generalises the combinational 8-to-3 encoder to WIDTH request lines.
- Two selectable modes: fixed priority (highest index wins) and round-robin (rotating fairness).
- Registered grant uses a valid/ready output handshake, so a downstream consumer can stall it.
- Sits between request sources (interrupt lines, channel requests) and a single shared consumer.

---
 rtl/prio_enc_pkg.sv | 18 +
 rtl/prio_find_high.sv | 24 ++
 rtl/prio_encoder_rr.sv | 107 ++++++++++
 tb/tb_prio_encoder_rr.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered round-robin/fixed priority encoder.
// Mode encodings and the one-hot helper are used by the RTL and the testbench.
package prio_enc_pkg;

    // Upper bound on request width supported by onehot_of.
    localparam int unsigned MAX_WIDTH = 256;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Callers narrow the result with a WIDTH'() cast.
    function automatic logic [MAX_WIDTH-1:0] onehot_of(input int unsigned idx);
        return MAX_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_find_high.sv
// Combinational highest-set-bit finder: found_o is set when any bit of vec_i
// is set, and idx_o is the index of the highest set bit (0 otherwise).
module prio_find_high #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Ascending scan: the last hit, i.e. the highest index, wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed (highest index wins) and round-robin
// modes; the grant is held under a valid/ready handshake until accepted.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] last_idx
);

    logic             valid_q,  valid_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0] last_q,   last_d;

    logic [WIDTH-1:0] below_mask;
    logic [WIDTH-1:0] req_masked;
    logic             masked_found;
    logic [IDX_W-1:0] masked_idx;
    logic             req_any;
    logic [IDX_W-1:0] full_idx;
    logic [IDX_W-1:0] grant_idx;
    logic             load;

    always_comb begin
        below_mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            below_mask[i] = (IDX_W'(i) < last_q);
        end
    end

    assign req_masked = req & below_mask;

    prio_find_high #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_find_masked (
        .vec_i   (req_masked),
        .found_o (masked_found),
        .idx_o   (masked_idx)
    );

    prio_find_high #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_find_full (
        .vec_i   (req),
        .found_o (req_any),
        .idx_o   (full_idx)
    );

    // Round-robin: the highest request below the pointer, else wrap to the
    // overall highest (which reaches last_q itself only when nothing else is set).
    always_comb begin
        if (mode == MODE_RR && masked_found) begin
            grant_idx = masked_idx;
        end else begin
            grant_idx = full_idx;
        end
    end

    assign load = !valid_q || out_ready;

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        last_d   = last_q;
        if (load) begin
            valid_d  = req_any;
            idx_d    = req_any ? grant_idx : '0;
            onehot_d = req_any ? WIDTH'(onehot_of(32'(grant_idx))) : '0;
            if (req_any && mode == MODE_RR) begin
                last_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            last_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            last_q   <= last_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign last_idx   = last_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Testbench for prio_encoder_rr: directed scenarios plus random traffic, with a
// behavioural model feeding an expectation queue drained by a separate monitor.
module tb_prio_encoder_rr;
    import prio_enc_pkg::*;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  req = '0;
    logic          mode = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic [W-1:0]  out_onehot;
    logic [IW-1:0] last_idx;

    prio_encoder_rr #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .last_idx   (last_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int idx;
        int last;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Reference state: what the outputs should read after the next edge.
    bit m_valid = 0;
    int m_idx   = 0;
    int m_last  = 0;

    task automatic model_step();
        int g;
        g = -1;
        if (rst) begin
            m_valid = 0; m_idx = 0; m_last = 0;
        end else if (!m_valid || out_ready) begin
            if (mode == MODE_FIXED) begin
                for (int i = W - 1; i >= 0; i--)
                    if (g < 0 && req[i]) g = i;
            end else begin
                // Walk last-1, last-2, ... modulo W, ending on last itself.
                for (int k = 1; k <= W; k++) begin
                    int c;
                    c = (m_last + W - k) % W;
                    if (g < 0 && req[c]) g = c;
                end
                if (g >= 0) m_last = g;
            end
            m_valid = (g >= 0);
            m_idx   = (g >= 0) ? g : 0;
        end
    endtask

    task automatic drive(input bit r, input logic [W-1:0] rq, input bit md, input bit rdy);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; mode = md; out_ready = rdy;
        cyc++;
        model_step();
        e.valid = m_valid; e.idx = m_idx; e.last = m_last; e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int c, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [W-1:0] eoh;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                eoh = '0;
                if (e.valid) eoh[e.idx] = 1'b1;
                check("out_valid", e.cyc, 32'(out_valid), int'(e.valid));
                check("out_idx", e.cyc, 32'(out_idx), e.idx);
                check("out_onehot", e.cyc, 32'(out_onehot), int'(eoh));
                check("last_idx", e.cyc, 32'(last_idx), e.last);
            end
        end
    end

    logic [W-1:0] rq;
    bit           rmode;

    initial begin : driver
        // Reset and idle
        drive(1, '0, 0, 1);
        drive(1, '0, 0, 1);
        repeat (3) drive(0, '0, 0, 1);

        // Fixed priority
        drive(0, 8'h01, 0, 1);
        drive(0, 8'h19, 0, 1);
        drive(0, 8'hA2, 0, 1);
        drive(0, 8'hFF, 0, 1);

        // Round-robin rotation with all requests held
        repeat (10) drive(0, 8'hFF, 1, 1);

        // Sparse/wrap: set pointer to 2, then alternate between 5 and 2
        drive(1, '0, 0, 1);
        drive(0, 8'h04, 1, 1);
        repeat (3) drive(0, 8'h24, 1, 1);
        // Lone requester equal to the pointer
        drive(0, 8'h08, 1, 1);
        drive(0, 8'h08, 1, 1);

        // Mode switch keeps the pointer, fixed grants leave it alone
        drive(0, 8'h81, 0, 1);
        drive(0, 8'h81, 1, 1);

        // Stall: hold grant 6 while req changes
        drive(0, 8'h40, 0, 1);
        repeat (3) drive(0, 8'h01, 0, 0);
        drive(0, 8'h01, 0, 1);
        drive(0, 8'h01, 0, 1);

        // Mid-operation reset with pointer at 5
        drive(0, 8'h20, 1, 1);
        drive(0, 8'h20, 1, 1);
        drive(1, 8'hFF, 1, 1);
        drive(0, 8'hFF, 1, 1);
        drive(0, 8'hFF, 1, 1);

        // Random traffic
        rmode = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) == 0) rmode = ~rmode;
            case ($urandom_range(0, 3))
                0: rq = '0;
                1: begin rq = '0; rq[$urandom_range(0, W - 1)] = 1'b1; end
                default: rq = W'($urandom);
            endcase
            drive($urandom_range(0, 99) < 2, rq, rmode, $urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
